// File: rtl/prng_pkg.sv
// Shared definitions for the PRNG word generator: maximal-length tap masks,
// the word-assembly FSM states and the default fallback seed.
package prng_pkg;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_000F;

    // Indexed by LFSR width; bit n set means state bit n feeds the XOR.
    localparam logic [31:0] TAP_MASK [0:32] = '{
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_000C, 32'h0000_0014, 32'h0000_0030, 32'h0000_0060,
        32'h0000_00B8, 32'h0000_0110, 32'h0000_0240, 32'h0000_0500,
        32'h0000_0829, 32'h0000_100D, 32'h0000_2015, 32'h0000_6000,
        32'h0000_D008, 32'h0001_2000, 32'h0002_0400, 32'h0004_0023,
        32'h0009_0000, 32'h0014_0000, 32'h0030_0000, 32'h0042_0000,
        32'h00E1_0000, 32'h0120_0000, 32'h0200_0023, 32'h0400_0013,
        32'h0900_0000, 32'h1400_0000, 32'h2000_0029, 32'h4800_0000,
        32'h8020_0003
    };

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/prng_word_gen_lfsr_core.sv
// Fibonacci LFSR register: shifts left with XOR feedback into bit 0,
// loads a new value on request, otherwise holds.
module lfsr_core
    import prng_pkg::*;
#(
    parameter int              WIDTH = 14,
    parameter logic [WIDTH-1:0] SEED = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(TAP_MASK[14])
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] loadValue_i,
    input  logic             shift_i,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic             feedback;

    assign feedback = ^(lfsr_q & TAPS);
    assign next_o   = {lfsr_q[WIDTH-2:0], feedback};

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = loadValue_i;
        end else if (shift_i) begin
            lfsr_d = next_o;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/prng_word_gen.sv
// Assembles OUT_BITS-shift windows of an LFSR sequence into words presented
// with a valid/ready handshake; the LFSR stops while a word waits.
module prng_word_gen
    import prng_pkg::*;
#(
    parameter int               WIDTH    = 14,
    parameter int               OUT_BITS = 14,
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEFAULT_SEED)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic                lockup
);

    localparam int          CNT_W    = $clog2(OUT_BITS + 1);
    localparam logic [31:0] TAP_FULL = TAP_MASK[WIDTH];

    if (WIDTH < 4 || WIDTH > 32) begin : gBadWidth
        $fatal(1, "prng_word_gen: WIDTH must be 4..32");
    end
    if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : gBadOutBits
        $fatal(1, "prng_word_gen: OUT_BITS must be 1..WIDTH");
    end
    if (SEED == '0) begin : gBadSeed
        $fatal(1, "prng_word_gen: SEED must be nonzero");
    end

    fsm_state_e          fsmState_q, fsmState_d;
    logic [CNT_W-1:0]    shiftCnt_q, shiftCnt_d;
    logic                outValid_q, outValid_d;
    logic [OUT_BITS-1:0] outData_q, outData_d;
    logic                lockup_q, lockup_d;
    logic                shiftEn;
    logic                seedIsZero;
    logic [WIDTH-1:0]    loadValue;
    logic [WIDTH-1:0]    lfsrNext;
    logic [CNT_W-1:0]    cntInc;

    assign seedIsZero = (seed_in == '0);
    assign loadValue  = seedIsZero ? SEED : seed_in;
    assign cntInc     = shiftCnt_q + CNT_W'(1);

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAP_FULL[WIDTH-1:0])
    ) uLfsr (
        .clk         (clk),
        .reset       (reset),
        .load_i      (seed_load),
        .loadValue_i (loadValue),
        .shift_i     (shiftEn),
        .next_o      (lfsrNext)
    );

    // Seed load beats everything; a handshake in HOLD doubles as the first
    // shift of the next word so back-to-back words cost OUT_BITS cycles each.
    always_comb begin
        fsmState_d = fsmState_q;
        shiftCnt_d = shiftCnt_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        lockup_d   = lockup_q;
        shiftEn    = 1'b0;
        if (seed_load) begin
            fsmState_d = ST_FILL;
            shiftCnt_d = '0;
            outValid_d = 1'b0;
            if (seedIsZero) begin
                lockup_d = 1'b1;
            end
        end else begin
            unique case (fsmState_q)
                ST_FILL: begin
                    if (enable) begin
                        shiftEn = 1'b1;
                        if (cntInc == CNT_W'(OUT_BITS)) begin
                            outData_d  = lfsrNext[OUT_BITS-1:0];
                            outValid_d = 1'b1;
                            shiftCnt_d = '0;
                            fsmState_d = ST_HOLD;
                        end else begin
                            shiftCnt_d = cntInc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        outValid_d = 1'b0;
                        fsmState_d = ST_FILL;
                        if (enable) begin
                            shiftEn = 1'b1;
                            if (OUT_BITS == 1) begin
                                outData_d  = lfsrNext[OUT_BITS-1:0];
                                outValid_d = 1'b1;
                                fsmState_d = ST_HOLD;
                            end else begin
                                shiftCnt_d = CNT_W'(1);
                            end
                        end
                    end
                end
                default: fsmState_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsmState_q <= ST_FILL;
            shiftCnt_q <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            lockup_q   <= 1'b0;
        end else begin
            fsmState_q <= fsmState_d;
            shiftCnt_q <= shiftCnt_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            lockup_q   <= lockup_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign lockup    = lockup_q;

endmodule

// File: tb/tb_prng_word_gen.sv
// Self-checking bench for prng_word_gen at WIDTH=4, OUT_BITS=4 (taps 3,2, SEED=F).
module tb_prng_word_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       seed_load = 1'b0;
    logic [3:0] seed_in = 4'h0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] out_data;
    logic       lockup;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] seed;
        logic [3:0] word;
    } vec_t;

    vec_t vecs [5];
    logic [3:0] expQ [$];

    always #5 clk = ~clk;

    prng_word_gen #(
        .WIDTH    (4),
        .OUT_BITS (4),
        .SEED     (4'hF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .lockup    (lockup)
    );

    function automatic logic [3:0] refShift(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives a one-cycle seed load with the given enable/ready levels.
    task automatic applyStimulus(input logic [3:0] seed, input logic en, input logic rdy);
        seed_in   = seed;
        seed_load = 1'b1;
        enable    = en;
        out_ready = rdy;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic waitValid(input int limit, input logic toggleEn, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < limit) begin
            if (toggleEn) enable = ~enable;
            tick();
            cycles++;
        end
        if (!out_valid) begin
            checkOutput("valid_timeout", 32'(out_valid), 32'd1);
        end
    endtask

    initial begin
        int lat;
        logic [3:0] held;
        logic [3:0] s;

        vecs[0] = '{seed: 4'h1, word: 4'h3};
        vecs[1] = '{seed: 4'h8, word: 4'h9};
        vecs[2] = '{seed: 4'hF, word: 4'h1};
        vecs[3] = '{seed: 4'hA, word: 4'hF};
        vecs[4] = '{seed: 4'h6, word: 4'hB};

        // Power-up reset and first word from SEED
        #12;
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_data", 32'(out_data), 32'd0);
        checkOutput("reset_lockup", 32'(lockup), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        waitValid(20, 1'b0, lat);
        checkOutput("powerup_latency", 32'(lat), 32'd4);
        checkOutput("powerup_word", 32'(out_data), 32'h1);

        // Table-driven: seed, first word, then word held with out_ready low
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].seed, 1'b1, 1'b0);
            checkOutput("load_clears_valid", 32'(out_valid), 32'd0);
            waitValid(20, 1'b0, lat);
            checkOutput("vec_latency", 32'(lat), 32'd4);
            checkOutput("vec_word", 32'(out_data), 32'(vecs[i].word));
            held = out_data;
            for (int k = 0; k < 10; k++) begin
                enable = k[0];
                tick();
                if (out_valid !== 1'b1 || out_data !== held) begin
                    checkOutput("hold_stable", {27'd0, out_valid, out_data}, {27'd0, 1'b1, held});
                end
            end
            checks++;
        end

        // Scoreboard streaming with out_ready high: 16 words cover a full period
        s = 4'h1;
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 4; b++) s = refShift(s);
            expQ.push_back(s);
        end
        applyStimulus(4'h1, 1'b1, 1'b1);
        begin
            int budget = 0;
            while (expQ.size() > 0 && budget < 200) begin
                if (out_valid) begin
                    checkOutput("stream_word", 32'(out_data), 32'(expQ.pop_front()));
                    checkOutput("stream_nonzero", 32'(out_data != 4'h0), 32'd1);
                end
                tick();
                budget++;
            end
            checkOutput("stream_drained", 32'(expQ.size()), 32'd0);
        end
        out_ready = 1'b0;

        // Zero seed falls back to SEED and sets the sticky lockup flag
        applyStimulus(4'h0, 1'b1, 1'b0);
        checkOutput("lockup_set", 32'(lockup), 32'd1);
        checkOutput("lockup_valid", 32'(out_valid), 32'd0);
        waitValid(20, 1'b0, lat);
        checkOutput("lockup_word", 32'(out_data), 32'h1);
        applyStimulus(4'h8, 1'b1, 1'b0);
        checkOutput("lockup_sticky", 32'(lockup), 32'd1);

        // Enable toggling every cycle halves the fill rate
        applyStimulus(4'h1, 1'b1, 1'b0);
        enable = 1'b1;
        waitValid(40, 1'b1, lat);
        checkOutput("toggle_latency", 32'(lat), 32'd8);
        checkOutput("toggle_word", 32'(out_data), 32'h3);

        // Seed load beats a simultaneous handshake in HOLD
        seed_in   = 4'h8;
        seed_load = 1'b1;
        out_ready = 1'b1;
        enable    = 1'b1;
        tick();
        seed_load = 1'b0;
        out_ready = 1'b0;
        checkOutput("seedwin_valid", 32'(out_valid), 32'd0);
        waitValid(20, 1'b0, lat);
        checkOutput("seedwin_latency", 32'(lat), 32'd4);
        checkOutput("seedwin_word", 32'(out_data), 32'h9);

        // Async reset mid-fill, then during HOLD
        applyStimulus(4'h6, 1'b1, 1'b0);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_fill_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_lockup_clear", 32'(lockup), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        waitValid(20, 1'b0, lat);
        checkOutput("rst_fill_latency", 32'(lat), 32'd4);
        checkOutput("rst_fill_word", 32'(out_data), 32'h1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_hold_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_hold_data", 32'(out_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        waitValid(20, 1'b0, lat);
        checkOutput("rst_hold_latency", 32'(lat), 32'd4);
        checkOutput("rst_hold_word", 32'(out_data), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
